// File: rtl/round_timer.sv
// round_timer: one-round game timer built around a one-second prescaler.
//
// A round runs while start_i is held high. Every CLK_FREQ cycles in RUN the
// elapsed-seconds count advances by one and sec_tick_o pulses. When the count
// reaches ROUND_LEN the timer parks in DONE with round_done_o pulsed once, and
// it waits there until start_i is seen low before a new round can begin.
//
// Parameters:
//   CLK_FREQ   clock cycles per one-second tick (2 .. 2**26)
//   ROUND_LEN  round length in seconds (1 .. 31)
// Ports:
//   clk_i           single clock, rising edge
//   rst_i           synchronous active-high reset
//   start_i         round-enable level; low aborts a running round
//   elasped_time_o  whole seconds elapsed in the current round (registered)
//   time_left_o     ROUND_LEN - elasped_time_o (registered, same cycle)
//   sec_tick_o      one-cycle pulse on each second boundary while running
//   running_o       high while in RUN
//   round_done_o    one-cycle pulse when elasped_time_o reaches ROUND_LEN
module round_timer #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned ROUND_LEN = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic [4:0] elasped_time_o,
  output logic [4:0] time_left_o,
  output logic       sec_tick_o,
  output logic       running_o,
  output logic       round_done_o
);

  localparam int unsigned    PreW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PreW-1:0] PreMax  = PreW'(CLK_FREQ - 1);
  localparam logic [4:0]     RoundLen = 5'(ROUND_LEN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [PreW-1:0]   pre_q;
  logic [4:0]        elapsed_q;
  logic [4:0]        time_left_q;
  logic              sec_tick_q;
  logic              running_q;
  logic              round_done_q;

  logic [4:0]        elapsed_inc;

  // Only used on a wrap in RUN, where elapsed_q < ROUND_LEN, so no overflow.
  assign elapsed_inc = elapsed_q + 5'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pre_q        <= '0;
      elapsed_q    <= '0;
      time_left_q  <= RoundLen;
      sec_tick_q   <= 1'b0;
      running_q    <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      // Pulses default low; only the wrap branch in RUN raises them.
      sec_tick_q   <= 1'b0;
      round_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pre_q       <= '0;
          elapsed_q   <= '0;
          time_left_q <= RoundLen;
          if (start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (!start_i) begin
            // Abort beats a coinciding second boundary.
            state_q     <= StIdle;
            running_q   <= 1'b0;
            pre_q       <= '0;
            elapsed_q   <= '0;
            time_left_q <= RoundLen;
          end else if (pre_q == PreMax) begin
            pre_q       <= '0;
            sec_tick_q  <= 1'b1;
            elapsed_q   <= elapsed_inc;
            time_left_q <= RoundLen - elapsed_inc;
            if (elapsed_inc == RoundLen) begin
              state_q      <= StDone;
              running_q    <= 1'b0;
              round_done_q <= 1'b1;
            end
          end else begin
            pre_q <= pre_q + PreW'(1);
          end
        end
        StDone: begin
          pre_q <= '0;
          // Clearing here keeps a stale ROUND_LEN from ending the next round.
          if (!start_i) begin
            state_q     <= StIdle;
            elapsed_q   <= '0;
            time_left_q <= RoundLen;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign elasped_time_o = elapsed_q;
  assign time_left_o    = time_left_q;
  assign sec_tick_o     = sec_tick_q;
  assign running_o      = running_q;
  assign round_done_o   = round_done_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer at CLK_FREQ=4, ROUND_LEN=3. Each step drives
// inputs, pushes the expected post-edge outputs from a cycle-counting model onto
// a queue, then pops and compares once the edge has happened.
module tb_round_timer;

  localparam int unsigned CF = 4;
  localparam int unsigned RL = 3;

  typedef struct packed {
    logic [4:0] el;
    logic [4:0] tl;
    logic       tick;
    logic       run;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] elasped_time;
  logic [4:0] time_left;
  logic       sec_tick;
  logic       running;
  logic       round_done;

  int vectors;
  int miscompares;

  obs_t exp_q[$];

  // Reference model: 0 idle, 1 run, 2 done; cyc counts cycles since the last
  // second boundary within RUN.
  int m_state;
  int m_cyc;
  int m_el;

  round_timer #(
    .CLK_FREQ (CF),
    .ROUND_LEN(RL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .elasped_time_o(elasped_time),
    .time_left_o   (time_left),
    .sec_tick_o    (sec_tick),
    .running_o     (running),
    .round_done_o  (round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_push(input logic r, input logic s);
    obs_t e;
    logic tick;
    logic done;
    tick = 1'b0;
    done = 1'b0;
    if (r) begin
      m_state = 0;
      m_cyc   = 0;
      m_el    = 0;
    end else begin
      case (m_state)
        0: begin
          m_cyc = 0;
          m_el  = 0;
          if (s) m_state = 1;
        end
        1: begin
          if (!s) begin
            m_state = 0;
            m_cyc   = 0;
            m_el    = 0;
          end else begin
            m_cyc = m_cyc + 1;
            if (m_cyc == CF) begin
              m_cyc = 0;
              m_el  = m_el + 1;
              tick  = 1'b1;
              if (m_el == RL) begin
                done    = 1'b1;
                m_state = 2;
              end
            end
          end
        end
        default: begin
          if (!s) begin
            m_state = 0;
            m_el    = 0;
          end
        end
      endcase
    end
    e.el   = 5'(m_el);
    e.tl   = 5'(RL - m_el);
    e.tick = tick;
    e.run  = (m_state == 1);
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input string tag);
    obs_t o;
    obs_t e;
    rst   = r;
    start = s;
    model_push(r, s);
    @(posedge clk);
    #1;
    o = '{el: elasped_time, tl: time_left, tick: sec_tick, run: running, done: round_done};
    e = exp_q.pop_front();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed el=%0d tl=%0d tick=%b run=%b done=%b, expected el=%0d tl=%0d tick=%b run=%b done=%b",
             tag, o.el, o.tl, o.tick, o.run, o.done, e.el, e.tl, e.tick, e.run, e.done);
    end
  endtask

  // Hand-written spot checks at points fixed by the round timing.
  task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_state     = 0;
    m_cyc       = 0;
    m_el        = 0;
    rst         = 1'b1;
    start       = 1'b1;

    // Reset for two cycles with start already high.
    step(1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, "reset1");
    check5("reset_tl", time_left, 5'd3);
    check5("reset_run", {4'd0, running}, 5'd0);

    // Full round: RUN entry, ticks at RUN cycles 4, 8, 12.
    step(1'b0, 1'b1, "run_entry");
    check5("run_entry_running", {4'd0, running}, 5'd1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, "round");
      if (i == 4)  check5("tick1_el", elasped_time, 5'd1);
      if (i == 8)  check5("tick2_tl", time_left, 5'd1);
      if (i == 11) check5("pre_tick3_tick", {4'd0, sec_tick}, 5'd0);
    end
    check5("tick3_done", {4'd0, round_done}, 5'd1);
    check5("tick3_tl", time_left, 5'd0);
    check5("tick3_el", elasped_time, 5'd3);

    // Hold start in DONE: no new round, no pulses.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "done_hold");
    check5("done_hold_el", elasped_time, 5'd3);
    step(1'b0, 1'b0, "done_release");
    check5("done_release_el", elasped_time, 5'd0);
    check5("done_release_tl", time_left, 5'd3);

    // Abort at RUN cycle 6, then restart from zero.
    step(1'b0, 1'b1, "abort_entry");
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, "abort_run");
    check5("abort_pre_el", elasped_time, 5'd1);
    step(1'b0, 1'b0, "abort");
    check5("abort_el", elasped_time, 5'd0);
    step(1'b0, 1'b1, "restart_entry");
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, "restart_run");
    check5("restart_tick", {4'd0, sec_tick}, 5'd1);

    // Abort on the exact wrap edge: abort wins, no tick.
    step(1'b0, 1'b0, "wrap_clear");
    step(1'b0, 1'b1, "wrap_entry");
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, "wrap_run");
    step(1'b0, 1'b0, "wrap_abort");
    check5("wrap_abort_tick", {4'd0, sec_tick}, 5'd0);
    check5("wrap_abort_el", elasped_time, 5'd0);

    // Reset mid-RUN at elapsed 2, then release with start high.
    step(1'b0, 1'b1, "rst_entry");
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, "rst_run");
    check5("rst_pre_el", elasped_time, 5'd2);
    step(1'b1, 1'b1, "rst_mid_run");
    step(1'b0, 1'b1, "rst_release");
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, "rst_recount");
    check5("rst_recount_el", elasped_time, 5'd1);

    // Random phase: start mostly high, occasional drops and resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) != 0), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, SHALL set clock cycles per one-second tick (legal range 2 to 2^26).
REQ-002 Parameter ROUND_LEN, default 30, SHALL set round length in seconds (legal range 1 to 31).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  SHALL be the round-enable level from the game-start logic; high means a round is in progress.
REQ-006 elasped_time  output  5  SHALL give whole seconds elapsed in the current round (registered).
REQ-007 time_left  output  5  SHALL equal ROUND_LEN minus elasped_time (registered, same cycle as elasped_time).
REQ-008 sec_tick  output  1  SHALL be a one-cycle pulse on each second boundary while running.
REQ-009 running  output  1  SHALL be high while the state is RUN.
REQ-010 round_done  output  1  SHALL be a one-cycle pulse when elasped_time reaches ROUND_LEN.

Function
REQ-011 States SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-012 IDLE: elasped_time=0, time_left=ROUND_LEN, prescaler=0; start=1 sampled -> RUN next cycle.
REQ-013 RUN: prescaler SHALL count 0..CLK_FREQ-1 and wrap to 0; on the wrap cycle, elasped_time SHALL increment by 1 and sec_tick SHALL pulse in that same registered update.
REQ-014 First increment SHALL occur exactly CLK_FREQ cycles after the first RUN cycle.
REQ-015 When the increment makes elasped_time equal ROUND_LEN: state -> DONE, round_done pulses 1 cycle coincident with that update, time_left=0.
REQ-016 elasped_time SHALL saturate at ROUND_LEN; it SHALL never exceed ROUND_LEN or wrap.
REQ-017 DONE: elasped_time held at ROUND_LEN, prescaler held at 0, no sec_tick; start=0 sampled -> IDLE, which clears elasped_time to 0 on that transition.
REQ-018 DONE with start=1 held SHALL remain in DONE (no new round until start has been seen low).
REQ-019 RUN with start=0 sampled (abort) SHALL go to IDLE next cycle, clearing elasped_time and prescaler; no round_done, no sec_tick that cycle even if prescaler was at wrap.
REQ-020 Abort and second boundary in the same cycle: abort SHALL win.
REQ-021 Clearing elasped_time in IDLE is mandatory so a fresh start is not immediately cancelled by a stale elapsed value of ROUND_LEN.
REQ-022 sec_tick and round_done SHALL never be high outside the cycle of the triggering increment.
REQ-023 Prescaler width SHALL be clog2(CLK_FREQ); comparison against CLK_FREQ-1 SHALL be width-correct for all legal parameters.

Reset
REQ-024 rst=1 SHALL force IDLE, elasped_time=0, time_left=ROUND_LEN, prescaler=0, sec_tick=0, running=0, round_done=0 on the next edge.
REQ-025 rst SHALL take priority over start and over all state transitions, including mid-RUN and in DONE.
REQ-026 After rst deasserts with start=1, the block SHALL enter RUN on the following edge and count from 0.

Verification (CLK_FREQ=4, ROUND_LEN=3 unless stated)
REQ-027 rst 2 cycles, start=1 from cycle 0 -> running=1 next cycle; sec_tick at RUN cycles 4, 8, 12; elasped_time 1,2,3; round_done with the 3rd tick; time_left 2,1,0.
REQ-028 Full round then start held 1 for 10 cycles -> stays DONE, elasped_time=3, no pulses; start=0 -> IDLE, elasped_time=0, time_left=3.
REQ-029 start dropped at RUN cycle 6 (elasped_time=1) -> IDLE next cycle, elasped_time=0, no round_done; restart counts from 0, first tick 4 cycles later.
REQ-030 start dropped on exact wrap cycle (RUN cycle 4) -> no sec_tick, elasped_time stays 0.
REQ-031 rst asserted in RUN at elasped_time=2 with start=1 -> all outputs at reset values next edge; rst released -> RUN, first tick 4 cycles later.
REQ-032 Defaults CLK_FREQ=50000000, ROUND_LEN=30 -> round_done at exactly 1500000000 cycles after RUN entry; elasped_time=30, never 31.
